// File: rtl/axis_msg_len_meter.sv
// Passive AXI-Stream message length meter.
// Sums tkeep popcount over every beat of a message, saturating at the
// accumulator width, and queues each finished length (with a clamp flag)
// into a show-ahead result FIFO. Status registers track the most recent
// length, whether a message is open, and message and drop counts.
module axis_msg_len_meter #(
    parameter int unsigned TKEEP_WIDTH    = 8,
    parameter int unsigned NUM_COUNT_BITS = 16,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MSG_CNT_BITS   = 32,
    parameter int unsigned DROP_CNT_BITS  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      s_tvalid,
    input  logic                      s_tready,
    input  logic                      s_tlast,
    input  logic [TKEEP_WIDTH-1:0]    s_tkeep,
    output logic                      m_len_valid,
    input  logic                      m_len_ready,
    output logic [NUM_COUNT_BITS-1:0] m_len,
    output logic                      m_len_sat,
    output logic [NUM_COUNT_BITS-1:0] last_len,
    output logic                      in_msg,
    output logic [MSG_CNT_BITS-1:0]   msg_count,
    output logic [DROP_CNT_BITS-1:0]  drop_count
);

    localparam int unsigned BYTE_W = $clog2(TKEEP_WIDTH + 1);
    localparam int unsigned SUM_W  = ((NUM_COUNT_BITS > BYTE_W) ? NUM_COUNT_BITS : BYTE_W) + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W  = NUM_COUNT_BITS + 1;

    localparam logic [SUM_W-1:0] MAX_SUM = {{(SUM_W - NUM_COUNT_BITS){1'b0}}, {NUM_COUNT_BITS{1'b1}}};

    // Accumulator and FIFO state.
    logic [NUM_COUNT_BITS-1:0] acc;
    logic                      sat_acc;
    logic [ENT_W-1:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [OCC_W-1:0]          occ;

    // Next-state terms.
    logic                      beat;
    logic [BYTE_W-1:0]         beat_bytes;
    logic [SUM_W-1:0]          sum;
    logic                      sum_sat;
    logic [NUM_COUNT_BITS-1:0] sum_len;
    logic                      res_sat;
    logic [ENT_W-1:0]          res_entry;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      push_ok;
    logic                      drop;
    logic [PTR_W-1:0]          rd_next;
    logic [PTR_W-1:0]          wr_next;
    logic [OCC_W-1:0]          occ_after_pop;
    logic [OCC_W-1:0]          occ_next;
    logic [ENT_W-1:0]          head_next;

    // Beat decode, saturating sum and FIFO bookkeeping for the coming edge.
    always_comb begin
        beat       = s_tvalid & s_tready;
        beat_bytes = '0;
        for (int unsigned i = 0; i < TKEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + BYTE_W'(s_tkeep[i]);
        end
        sum       = SUM_W'(acc) + SUM_W'(beat_bytes);
        sum_sat   = (sum > MAX_SUM);
        sum_len   = sum_sat ? {NUM_COUNT_BITS{1'b1}} : sum[NUM_COUNT_BITS-1:0];
        res_sat   = sat_acc | sum_sat;
        res_entry = {res_sat, sum_len};

        push    = beat & s_tlast;
        pop     = m_len_valid & m_len_ready;
        full    = (occ == OCC_W'(FIFO_DEPTH));
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;

        rd_next       = pop     ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_next       = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
        occ_after_pop = occ - OCC_W'(pop);
        occ_next      = occ_after_pop + OCC_W'(push_ok);

        // Head after the edge: the pushed entry if nothing older remains,
        // otherwise the stored entry; an empty FIFO keeps the last value shown.
        head_next = {m_len_sat, m_len};
        if (occ_next != '0) begin
            if (push_ok && (occ_after_pop == '0)) begin
                head_next = res_entry;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Result storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem[wr_ptr] <= res_entry;
        end
    end

    // Accumulator, FIFO pointers, registered outputs and status counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            sat_acc     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            m_len_valid <= 1'b0;
            m_len       <= '0;
            m_len_sat   <= 1'b0;
            last_len    <= '0;
            in_msg      <= 1'b0;
            msg_count   <= '0;
            drop_count  <= '0;
        end else if (clr) begin
            acc         <= '0;
            sat_acc     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            m_len_valid <= 1'b0;
            m_len       <= '0;
            m_len_sat   <= 1'b0;
            last_len    <= '0;
            in_msg      <= 1'b0;
            msg_count   <= '0;
            drop_count  <= '0;
        end else begin
            if (beat) begin
                if (s_tlast) begin
                    acc       <= '0;
                    sat_acc   <= 1'b0;
                    in_msg    <= 1'b0;
                    last_len  <= sum_len;
                    msg_count <= msg_count + MSG_CNT_BITS'(1);
                end else begin
                    acc     <= sum_len;
                    sat_acc <= res_sat;
                    in_msg  <= 1'b1;
                end
            end
            if (drop && (drop_count != {DROP_CNT_BITS{1'b1}})) begin
                drop_count <= drop_count + DROP_CNT_BITS'(1);
            end
            wr_ptr      <= wr_next;
            rd_ptr      <= rd_next;
            occ         <= occ_next;
            m_len_valid <= (occ_next != '0);
            m_len       <= head_next[NUM_COUNT_BITS-1:0];
            m_len_sat   <= head_next[NUM_COUNT_BITS];
        end
    end

endmodule

// File: tb/tb_axis_msg_len_meter.sv
// Directed bench for axis_msg_len_meter: a per-cycle vector table for the
// basic message flows, then hand-written sequences for saturation, FIFO
// overflow, clear and asynchronous reset.
module tb_axis_msg_len_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  s_tkeep;
    logic        m_len_ready;

    logic        m_len_valid;
    logic [15:0] m_len;
    logic        m_len_sat;
    logic [15:0] last_len;
    logic        in_msg;
    logic [31:0] msg_count;
    logic [15:0] drop_count;

    logic        n4_valid;
    logic [3:0]  n4_len;
    logic        n4_sat;
    logic [3:0]  n4_last_len;
    logic        n4_in_msg;
    logic [31:0] n4_msg_count;
    logic [15:0] n4_drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_msg_len_meter dut (
        .clk(clk), .rst(rst), .clr(clr),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
        .m_len_valid(m_len_valid), .m_len_ready(m_len_ready),
        .m_len(m_len), .m_len_sat(m_len_sat), .last_len(last_len),
        .in_msg(in_msg), .msg_count(msg_count), .drop_count(drop_count)
    );

    axis_msg_len_meter #(.NUM_COUNT_BITS(4)) dut_n4 (
        .clk(clk), .rst(rst), .clr(clr),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
        .m_len_valid(n4_valid), .m_len_ready(m_len_ready),
        .m_len(n4_len), .m_len_sat(n4_sat), .last_len(n4_last_len),
        .in_msg(n4_in_msg), .msg_count(n4_msg_count), .drop_count(n4_drop)
    );

    typedef struct {
        int tvalid;
        int tlast;
        int tkeep;
        int ready;
        int valid;
        int len;
        int sat;
        int last_len;
        int in_msg;
        int mc;
        int drop;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int l, input int k, input int r);
        s_tvalid    = 1'(v);
        s_tlast     = 1'(l);
        s_tkeep     = 8'(k);
        m_len_ready = 1'(r);
    endtask

    task automatic check_status_zero(input string tag);
        check({tag, "_valid"}, int'(m_len_valid), 0);
        check({tag, "_len"}, int'(m_len), 0);
        check({tag, "_sat"}, int'(m_len_sat), 0);
        check({tag, "_last_len"}, int'(last_len), 0);
        check({tag, "_in_msg"}, int'(in_msg), 0);
        check({tag, "_msg_count"}, int'(msg_count), 0);
        check({tag, "_drop"}, int'(drop_count), 0);
    endtask

    initial begin
        int drain_exp [3];
        // tvalid tlast tkeep ready | valid len sat last_len in_msg mc drop
        vecs[0] = '{1, 0, 'hFF, 1, 0,  0, 0,  0, 1, 0, 0};
        vecs[1] = '{1, 0, 'hFF, 1, 0,  0, 0,  0, 1, 0, 0};
        vecs[2] = '{1, 1, 'h0F, 1, 1, 20, 0, 20, 0, 1, 0};
        vecs[3] = '{0, 0, 'h00, 1, 0, 20, 0, 20, 0, 1, 0};
        vecs[4] = '{1, 1, 'h00, 1, 1,  0, 0,  0, 0, 2, 0};
        vecs[5] = '{1, 1, 'h01, 1, 1,  1, 0,  1, 0, 3, 0};
        vecs[6] = '{0, 0, 'h00, 1, 0,  1, 0,  1, 0, 3, 0};
        drain_exp = '{3, 4, 8};

        rst = 1'b0;
        clr = 1'b0;
        s_tready = 1'b1;
        drive(0, 0, 0, 0);
        step();
        check_status_zero("reset");
        rst = 1'b1;
        step();

        // Basic flows: three-beat message, zero-byte and one-byte messages.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].tvalid, vecs[i].tlast, vecs[i].tkeep, vecs[i].ready);
            step();
            check($sformatf("vec%0d_valid", i), int'(m_len_valid), vecs[i].valid);
            check($sformatf("vec%0d_len", i), int'(m_len), vecs[i].len);
            check($sformatf("vec%0d_sat", i), int'(m_len_sat), vecs[i].sat);
            check($sformatf("vec%0d_last_len", i), int'(last_len), vecs[i].last_len);
            check($sformatf("vec%0d_in_msg", i), int'(in_msg), vecs[i].in_msg);
            check($sformatf("vec%0d_msg_count", i), int'(msg_count), vecs[i].mc);
            check($sformatf("vec%0d_drop", i), int'(drop_count), vecs[i].drop);
        end

        // Saturation on the 4-bit instance.
        clr = 1'b1;
        drive(0, 0, 0, 1);
        step();
        clr = 1'b0;
        drive(1, 0, 'hFF, 1);
        step();
        check("sat_in_msg", int'(n4_in_msg), 1);
        step();
        drive(1, 1, 'hFF, 1);
        step();
        check("sat_valid", int'(n4_valid), 1);
        check("sat_len", int'(n4_len), 15);
        check("sat_flag", int'(n4_sat), 1);
        check("sat_last_len", int'(n4_last_len), 15);
        check("sat_wide_len", int'(m_len), 24);
        check("sat_wide_flag", int'(m_len_sat), 0);
        drive(1, 1, 'h03, 1);
        step();
        check("post_sat_len", int'(n4_len), 2);
        check("post_sat_flag", int'(n4_sat), 0);
        check("post_sat_msg_count", int'(n4_msg_count), 2);
        drive(1, 0, 'hFF, 1);
        step();
        check("post_sat_popped", int'(n4_valid), 0);
        drive(1, 1, 'h7F, 1);
        step();
        check("exact_max_len", int'(n4_len), 15);
        check("exact_max_flag", int'(n4_sat), 0);
        check("exact_max_wide", int'(m_len), 15);
        drive(0, 0, 0, 1);
        step();
        check("sat_drained", int'(n4_valid), 0);
        check("sat_drop", int'(n4_drop), 0);
        check("sat_in_msg_end", int'(n4_in_msg), 0);

        // FIFO overflow with the consumer stalled.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(1, 1, (1 << k) - 1, 0);
            step();
        end
        drive(0, 0, 0, 0);
        check("full_head", int'(m_len), 1);
        check("full_valid", int'(m_len_valid), 1);
        check("full_drop", int'(drop_count), 2);
        check("full_last_len", int'(last_len), 6);
        check("full_msg_count", int'(msg_count), 6);
        step();
        check("full_hold_head", int'(m_len), 1);
        drive(1, 1, 'hFF, 1);
        step();
        check("full_pushpop_head", int'(m_len), 2);
        check("full_pushpop_drop", int'(drop_count), 2);
        check("full_pushpop_last_len", int'(last_len), 8);
        check("full_pushpop_msg_count", int'(msg_count), 7);
        drive(0, 0, 0, 1);
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("drain%0d_valid", j), int'(m_len_valid), 1);
            check($sformatf("drain%0d_len", j), int'(m_len), drain_exp[j]);
        end
        step();
        check("drain_empty_valid", int'(m_len_valid), 0);
        check("drain_empty_hold", int'(m_len), 8);

        // Synchronous clear mid-message with a concurrent beat.
        drive(1, 1, 'h01, 0);
        step();
        drive(1, 0, 'hFF, 0);
        step();
        step();
        check("clr_pre_in_msg", int'(in_msg), 1);
        check("clr_pre_valid", int'(m_len_valid), 1);
        clr = 1'b1;
        drive(1, 1, 'hFF, 1);
        step();
        clr = 1'b0;
        check_status_zero("clr");
        drive(1, 1, 'h01, 0);
        step();
        check("clr_next_len", int'(m_len), 1);
        check("clr_next_valid", int'(m_len_valid), 1);
        check("clr_next_msg_count", int'(msg_count), 1);

        // Asynchronous reset mid-message, between clock edges.
        drive(1, 0, 'hFF, 0);
        step();
        step();
        check("arst_pre_in_msg", int'(in_msg), 1);
        drive(0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check_status_zero("arst");
        #1;
        rst = 1'b1;
        drive(1, 1, 'h01, 0);
        step();
        check("arst_next_len", int'(m_len), 1);
        check("arst_next_valid", int'(m_len_valid), 1);
        check("arst_next_last_len", int'(last_len), 1);
        check("arst_next_msg_count", int'(msg_count), 1);
        check("arst_next_in_msg", int'(in_msg), 0);
        drive(0, 0, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
